// File: rtl/gf180mcu_fd_sc_mcu7t5v0__latq_bank.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__latq_bank.sv - multi-channel enable-qualified storage bank with sequenced retention save/restore
module gf180mcu_fd_sc_mcu7t5v0__latq_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4,
    localparam int SW      = $clog2(DEPTH)
) (
    input  logic                        CLK,
    input  logic                        RN,
    input  logic [CHANNELS-1:0]         E,
    input  logic [CHANNELS*WIDTH-1:0]   D,
    input  logic                        SAVE,
    input  logic                        RESTORE,
    input  logic [SW-1:0]               SLOT,
    input  logic                        notifier,
    output logic [CHANNELS*WIDTH-1:0]   Q,
    output logic                        BUSY,
    output logic                        VIOL
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVING,
        ST_RESTORING
    } state_e;

    state_e            state_q;
    logic              busy_q;
    logic              viol_q;
    logic              notif_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [SW-1:0]     slot_q;
    logic [WIDTH-1:0]  q_q      [CHANNELS];
    logic [WIDTH-1:0]  slot_mem [DEPTH][CHANNELS];
    logic              viol_det;

    // Any level change on the notifier line since the last edge is one violation.
    assign viol_det = (notifier != notif_q);
    assign cnt_d    = cnt_q + CW'(1);

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            viol_q  <= 1'b0;
            notif_q <= notifier;
            cnt_q   <= '0;
            slot_q  <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                q_q[k] <= '0;
            end
            for (int s = 0; s < DEPTH; s++) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    slot_mem[s][k] <= '0;
                end
            end
        end else begin
            notif_q <= notifier;
            if (viol_det) begin
                viol_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        if (E[k] && !viol_det) begin
                            q_q[k] <= D[k*WIDTH +: WIDTH];
                        end
                    end
                    if (RESTORE) begin
                        state_q <= ST_RESTORING;
                        busy_q  <= 1'b1;
                        slot_q  <= SLOT;
                        cnt_q   <= '0;
                    end else if (SAVE) begin
                        state_q <= ST_SAVING;
                        busy_q  <= 1'b1;
                        slot_q  <= SLOT;
                        cnt_q   <= '0;
                    end
                end

                ST_SAVING, ST_RESTORING: begin
                    // One channel per cycle; inputs other than reset are ignored here.
                    if (state_q == ST_SAVING) begin
                        slot_mem[slot_q][cnt_q] <= q_q[cnt_q];
                    end else begin
                        q_q[cnt_q] <= slot_mem[slot_q][cnt_q];
                    end
                    if (cnt_q == LAST_CH) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_pack
        assign Q[k*WIDTH +: WIDTH] = q_q[k];
    end

    assign BUSY = busy_q;
    assign VIOL = viol_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__latq_bank.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__latq_bank.sv - directed and randomized checks of the storage bank against a reference model
module tb_gf180mcu_fd_sc_mcu7t5v0__latq_bank;

    logic        clk = 1'b0;
    logic        rn = 1'b0;
    logic [3:0]  e = '0;
    logic [31:0] d = '0;
    logic        save = 1'b0;
    logic        restore = 1'b0;
    logic [1:0]  slot = '0;
    logic        notif = 1'b0;
    logic [31:0] q;
    logic        busy;
    logic        viol;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: channel contents, retention slots, and an in-flight
    // transfer described by its direction, slot and edges elapsed.
    logic [7:0] m_q    [4];
    logic [7:0] m_slot [4][4];
    bit         m_op_active;
    bit         m_op_restore;
    logic [1:0] m_op_slot;
    int         m_op_edges;
    bit         m_viol;
    logic       m_hist;

    gf180mcu_fd_sc_mcu7t5v0__latq_bank #(
        .WIDTH(8), .CHANNELS(4), .DEPTH(4)
    ) dut (
        .CLK(clk), .RN(rn), .E(e), .D(d), .SAVE(save), .RESTORE(restore),
        .SLOT(slot), .notifier(notif), .Q(q), .BUSY(busy), .VIOL(viol)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_packed();
        return {m_q[3], m_q[2], m_q[1], m_q[0]};
    endfunction

    task automatic model_edge();
        bit vdet;
        int ch;
        if (!rn) begin
            foreach (m_q[k]) m_q[k] = '0;
            foreach (m_slot[s, k]) m_slot[s][k] = '0;
            m_op_active = 0;
            m_viol = 0;
            m_hist = notif;
            return;
        end
        vdet = (notif != m_hist);
        m_hist = notif;
        if (vdet) m_viol = 1;
        if (!m_op_active) begin
            for (int k = 0; k < 4; k++)
                if (e[k] && !vdet) m_q[k] = d[k*8 +: 8];
            if (restore || save) begin
                m_op_active  = 1;
                m_op_restore = restore;
                m_op_slot    = slot;
                m_op_edges   = 0;
            end
        end else begin
            m_op_edges++;
            ch = m_op_edges - 1;
            if (m_op_restore) m_q[ch] = m_slot[m_op_slot][ch];
            else m_slot[m_op_slot][ch] = m_q[ch];
            if (m_op_edges == 4) m_op_active = 0;
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] en, input logic [31:0] dat,
                       input logic sv, input logic rs, input logic [1:0] sl);
        rn = r; e = en; d = dat; save = sv; restore = rs; slot = sl;
        @(posedge clk);
        model_edge();
        #1;
        check("Q", q, m_packed());
        check("BUSY", {31'b0, busy}, {31'b0, m_op_active});
        check("VIOL", {31'b0, viol}, {31'b0, m_viol});
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1, 4'h0, $urandom, 0, 0, 2'd0);
    endtask

    initial begin
        int busy_cnt;
        notif = 1'b0;
        #2;

        cyc(0, 4'h0, 32'h0, 0, 0, 2'd0);
        check("reset_q", q, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_viol", {31'b0, viol}, 32'h0);

        cyc(1, 4'b0101, 32'hDDCCBBAA, 0, 0, 2'd0);
        check("capture_masked", q, 32'h00CC00AA);
        cyc(1, 4'b0000, 32'h12345678, 0, 0, 2'd0);
        check("capture_hold", q, 32'h00CC00AA);

        // Save/restore round trip through slot 2
        cyc(1, 4'hF, 32'h44332211, 0, 0, 2'd0);
        cyc(1, 4'h0, 32'h0, 1, 0, 2'd2);
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 4'h0, 32'h0, 0, 0, 2'd0);
            if (busy) busy_cnt++;
        end
        check("busy_len_save", busy_cnt, 32'd4);
        cyc(1, 4'hF, 32'h0, 0, 0, 2'd0);
        check("overwrite", q, 32'h0);
        cyc(1, 4'h0, 32'h0, 0, 1, 2'd2);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 4'h0, 32'h0, 0, 0, 2'd0);
            check("restore_byte", {24'b0, q[k*8 +: 8]}, {24'b0, 8'(8'h11 * (k + 1))});
        end
        check("restore_final", q, 32'h44332211);

        // Priority and lockout: RESTORE wins, E ignored while busy
        cyc(1, 4'hF, 32'hAABBCCDD, 0, 0, 2'd0);
        cyc(1, 4'h0, 32'h0, 1, 1, 2'd2);
        for (int i = 0; i < 4; i++) cyc(1, 4'hF, 32'hFFFFFFFF, 1, 0, 2'd1);
        check("priority_restore", q, 32'h44332211);
        cyc(1, 4'hF, 32'h0, 0, 0, 2'd0);
        cyc(1, 4'h0, 32'h0, 0, 1, 2'd2);
        idle_cycles(4);
        check("slot_unmodified", q, 32'h44332211);

        // Slot isolation
        cyc(1, 4'hF, 32'h11111111, 0, 0, 2'd0);
        cyc(1, 4'h0, 32'h0, 1, 0, 2'd0);
        idle_cycles(4);
        cyc(1, 4'hF, 32'h22222222, 0, 0, 2'd0);
        cyc(1, 4'h0, 32'h0, 1, 0, 2'd3);
        idle_cycles(4);
        cyc(1, 4'h0, 32'h0, 0, 1, 2'd0);
        idle_cycles(4);
        check("iso_slot0", q, 32'h11111111);
        cyc(1, 4'h0, 32'h0, 0, 1, 2'd1);
        idle_cycles(4);
        check("iso_slot1", q, 32'h0);

        // Violation: capture suppressed on the detecting edge, flag sticky
        notif = ~notif;
        cyc(1, 4'hF, 32'hFFFFFFFF, 0, 0, 2'd0);
        check("viol_hold_q", q, 32'h0);
        check("viol_set", {31'b0, viol}, 32'h1);
        cyc(1, 4'hF, 32'h5A5A5A5A, 0, 0, 2'd0);
        check("viol_capture_after", q, 32'h5A5A5A5A);
        check("viol_sticky", {31'b0, viol}, 32'h1);
        cyc(0, 4'h0, 32'h0, 0, 0, 2'd0);
        check("viol_cleared", {31'b0, viol}, 32'h0);
        cyc(1, 4'h0, 32'h0, 0, 0, 2'd0);
        check("no_false_viol", {31'b0, viol}, 32'h0);

        // Reset in the middle of a save
        cyc(1, 4'hF, 32'h77777777, 0, 0, 2'd0);
        cyc(1, 4'h0, 32'h0, 1, 0, 2'd1);
        cyc(1, 4'h0, 32'h0, 0, 0, 2'd0);
        cyc(0, 4'h0, 32'h0, 0, 0, 2'd0);
        check("midsave_busy", {31'b0, busy}, 32'h0);
        check("midsave_q", q, 32'h0);
        cyc(1, 4'h0, 32'h0, 0, 1, 2'd1);
        idle_cycles(4);
        check("midsave_slot", q, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) notif = ~notif;
            cyc(($urandom_range(0, 149) != 0), 4'($urandom), $urandom,
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                2'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
